// File: rtl/jk_reg_array.sv
// ---------------------------------------------------------------------------
// jk_reg_array
//
// Multi-bit JK register bank whose single state register q can also be
// operated as a synchronous up/down counter, a serial shift register or a
// set-dominant set/clear register. There is one registered core for all
// modes, and the mode is decoded combinationally in front of it.
//
// Parameters
//   WIDTH      number of bits in q (minimum 2)
//   RESET_VAL  value loaded into q by a synchronous reset
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, dominates everything
//   en    in   update enable; q holds in every mode when low
//   mode  in   00 JK, 01 COUNT, 10 SHIFT, 11 SETCLR
//   j, k  in   per-bit J/K (used in JK and SETCLR modes)
//   dir   in   COUNT: 0 up / 1 down, SHIFT: 0 left / 1 right
//   sin   in   serial input for SHIFT mode
//   q     out  register state
//   qbar  out  ~q
//   tc    out  terminal count: high in the cycle whose edge wraps the counter
//
// Flow control: there is no valid/ready handshake. en acts as a
// per-cycle qualifier. Every rising edge with en=1 and rst=0 performs
// exactly one update, so updates can occur back to back.
// ---------------------------------------------------------------------------
module jk_reg_array #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    localparam logic [1:0] MODE_JK     = 2'b00;
    localparam logic [1:0] MODE_COUNT  = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_SETCLR = 2'b11;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_next;

    // Next-state decode. The default is hold, which also covers en=0.
    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                // Characteristic JK equation: set where J and Q=0, keep where
                // K=0 and Q=1. J=K=1 therefore toggles.
                MODE_JK:     q_next = (j & ~q) | (~k & q);
                MODE_COUNT:  q_next = dir ? (q - ONE) : (q + ONE);
                MODE_SHIFT:  q_next = dir ? {sin, q[WIDTH-1:1]}
                                          : {q[WIDTH-2:0], sin};
                // J is ORed in after K clears, so J=K=1 sets.
                MODE_SETCLR: q_next = (q & ~k) | j;
                default:     q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

    assign qbar = ~q;

    // Terminal count looks at the current q and the current control inputs.
    // The following edge is the one that wraps the counter, so the flag can
    // drive the en input of a cascaded stage directly.
    assign tc = en && (mode == MODE_COUNT) &&
                (dir ? (q == '0) : (q == ALL_ONES));

endmodule
